dm_responder: RTL

- Data-memory responder: the slave end of the CPU's DM port (DM_address/DM_in/DM_enable/DM_write in; DM_out/stall out).
- Owns a word-addressed storage array and emulates a slow memory with a configurable number of wait states.
- Drives the CPU's global stall input so the pipeline freezes while an access is outstanding.
- Instantiated in the SoC top next to the CPU, replacing the testbench-side DM model.

---
 rtl/dm_pkg.sv | 20 ++
 rtl/dm_sram_array.sv | 37 +++
 rtl/dm_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the wait-counter width and the address-range check.
package dm_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_e;

  // Inputs are widened to 64 bits so the end-of-window sum cannot wrap.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] depth_words);
    return (addr >= base) && ((addr - base) < (depth_words << 2));
  endfunction

endpackage

// File: rtl/dm_sram_array.sv
// Single-port synchronous word array with a registered read port.
// The read register holds its value until the next read or a reset.
module dm_sram_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_en,
  input  logic             read_en,
  input  logic             read_clr,
  input  logic [IDX_W-1:0] index,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; only the read register does, so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[index] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (read_clr) begin
      rdata <= '0;
    end else if (read_en) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Slave end of the CPU data-memory port: emulates a slow memory with WAIT_CYCLES
// wait states and drives the CPU's stall while an access is outstanding.
module dm_responder
  import dm_pkg::*;
#(
  parameter int                 MEMSize     = 32,
  parameter int                 DEPTH_WORDS = 1024,
  parameter int                 WAIT_CYCLES = 2,
  parameter logic [MEMSize-1:0] BASE_ADDR   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MEMSize-1:0] DM_address,
  input  logic [MEMSize-1:0] DM_in,
  input  logic               DM_enable,
  input  logic               DM_write,
  output logic [MEMSize-1:0] DM_out,
  output logic               stall,
  output logic               addr_err
);

  localparam int               IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_M1 = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dm_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               access;
  logic               hit;
  logic               err_q;
  logic [MEMSize-1:0] offset;
  logic [IDX_W-1:0]   index;

  assign offset = DM_address - BASE_ADDR;
  assign index  = IDX_W'(offset >> 2);
  assign hit    = in_range(64'(DM_address), 64'(BASE_ADDR), 64'(DEPTH_WORDS));

  // The IDLE request cycle is the first stall cycle, so BUSY lasts WAIT_CYCLES-1 cycles
  // and the access lands on the edge where the counter reaches 1.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (DM_enable) begin
          if (WAIT_CYCLES == 0) begin
            access = 1'b1;
          end else begin
            stall = 1'b1;
            if (WAIT_M1 == '0) begin
              access  = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d   = WAIT_M1;
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        if (!DM_enable) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            access  = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset must drop stall at once and block any array write while held.
    if (!rst) begin
      stall  = 1'b0;
      access = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access && !hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign addr_err = err_q;

  dm_sram_array #(
    .WIDTH (MEMSize),
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst),
    .write_en (access && DM_write && hit),
    .read_en  (access && !DM_write && hit),
    .read_clr (access && !DM_write && !hit),
    .index    (index),
    .wdata    (DM_in),
    .rdata    (DM_out)
  );

endmodule
